regfile_wb: RTL and testbench

- Integer register file: the consumer end of the writeback stage.
- Accepts the selected writeback result (ALU, load or next_pc) and commits it to x1..x31.
- Serves two decode-stage read ports with same-cycle write bypass.
- Holds a per-register pending-write scoreboard so decode can stall on RAW hazards until the producing instruction has written back.

---
 rtl/jarvis_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 78 +++++++
 rtl/regfile_wb.sv | 72 +++++++
 tb/tb_regfile_wb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/jarvis_pkg.sv
// Shared core definitions used by decode, writeback and the register file.
// Register address width and writeback result-source encodings live here.
package jarvis_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters for RAW hazard detection.
// Tracks issued-but-uncommitted writes; x0 is never tracked.
module reg_scoreboard
  import jarvis_pkg::*;
#(
  parameter int NREGS        = NUM_REGS,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  issue_valid,
  input  logic                  issue_rd_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [CW-1:0]    cnt [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  logic             full;

  // A writeback only retires a tracked write, so counters never underflow
  always_comb begin
    dec = '0;
    for (int r = 1; r < NREGS; r++) begin
      dec[r] = wb_en && (wb_addr == REG_ADDR_W'(r))
             && (cnt[r] != '0);
    end
  end

  // Refuse an issue only when its target is saturated and not draining
  always_comb begin
    full = issue_valid && issue_rd_en
        && (issue_rd != '0)
        && (cnt[issue_rd] == MAX_CNT)
        && !dec[issue_rd];
    issue_ready = !full;
  end

  // Accepted issues to x1..x31 claim a slot
  always_comb begin
    inc = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc[r] = issue_valid && issue_rd_en && issue_ready
             && (issue_rd == REG_ADDR_W'(r));
    end
  end

  // Counter update; simultaneous inc and dec cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (inc[r] && !dec[r])      cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r]) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // Busy excludes a write retiring this cycle, since that data is bypassed
  always_comb begin
    rs1_busy = (rs1_addr != '0)
            && ((cnt[rs1_addr] - CW'(dec[rs1_addr])) != '0);
    rs2_busy = (rs2_addr != '0)
            && ((cnt[rs2_addr] - CW'(dec[rs2_addr])) != '0);
  end

endmodule

// File: rtl/regfile_wb.sv
// Integer register file at the writeback end of the pipeline.
// Two bypassed read ports plus a pending-write scoreboard for decode.
module regfile_wb
  import jarvis_pkg::*;
#(
  parameter int DW           = XLEN,
  parameter int NREGS        = NUM_REGS,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DW-1:0]         rs1_data,
  output logic [DW-1:0]         rs2_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DW-1:0]         wb_data,
  input  logic                  issue_valid,
  input  logic                  issue_rd_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall
);

  logic [DW-1:0] regs [NREGS];

  // Commit writeback results; x0 writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Write-first read ports with x0 forced to zero
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (wb_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
    if (wb_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

  reg_scoreboard #(
    .NREGS        (NREGS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

  // Decode holds whenever an operand is pending or the issue is refused
  always_comb begin
    stall = rs1_busy | rs2_busy | ~issue_ready;
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: bypass, x0, scoreboard limits, reset.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        issue_valid, issue_rd_en;
  logic [4:0]  issue_rd;
  logic        issue_ready, rs1_busy, rs2_busy, stall;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic cyc(input logic        we,
                     input logic [4:0]  wa,
                     input logic [31:0] wd,
                     input logic        iv,
                     input logic [4:0]  ird,
                     input logic [4:0]  a1,
                     input logic [4:0]  a2);
    @(negedge clk);
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    issue_valid = iv;
    issue_rd_en = iv;
    issue_rd    = ird;
    rs1_addr    = a1;
    rs2_addr    = a2;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    issue_valid = 0; issue_rd_en = 0; issue_rd = 0;
    rs1_addr = 5; rs2_addr = 0;

    // reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rs1_data", rs1_data, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_stall", stall, 0);
    @(negedge clk) rst_n = 1'b1;

    // bypass then stored read
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    chk("byp_rs1", rs1_data, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 5, 5);
    chk("held_rs1", rs1_data, 32'hDEADBEEF);
    chk("held_rs2", rs2_data, 32'hDEADBEEF);

    // x0 write dropped, x0 never busy
    cyc(1, 0, 32'h12345678, 0, 0, 0, 0);
    chk("x0_byp", rs2_data, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("x0_rd", rs2_data, 0);
    chk("x0_iss_rdy", issue_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("x0_busy", rs2_busy, 0);

    // saturate x7
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 7, 0, 0);
      chk("x7_iss_rdy", issue_ready, 1);
    end
    cyc(0, 0, 0, 1, 7, 0, 0);
    chk("x7_full_rdy", issue_ready, 0);
    chk("x7_full_stall", stall, 1);
    cyc(0, 0, 0, 0, 0, 7, 0);
    chk("x7_busy", rs1_busy, 1);
    cyc(1, 7, 32'h71, 0, 0, 7, 0);
    chk("x7_wb1_busy", rs1_busy, 1);
    cyc(1, 7, 32'h72, 0, 0, 7, 0);
    chk("x7_wb2_busy", rs1_busy, 1);
    cyc(1, 7, 32'h73, 0, 0, 7, 0);
    chk("x7_wb3_busy", rs1_busy, 0);
    chk("x7_wb3_data", rs1_data, 32'h73);
    cyc(0, 0, 0, 0, 0, 7, 0);
    chk("x7_idle_busy", rs1_busy, 0);
    chk("x7_idle_stall", stall, 0);

    // x9 at max with simultaneous issue and writeback
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 9, 0, 0);
    cyc(1, 9, 32'h90, 1, 9, 0, 9);
    chk("x9_swap_rdy", issue_ready, 1);
    chk("x9_swap_busy", rs2_busy, 1);
    cyc(0, 0, 0, 1, 9, 0, 9);
    chk("x9_still_full", issue_ready, 0);
    cyc(1, 9, 32'h91, 0, 0, 0, 9);
    chk("x9_wb1_busy", rs2_busy, 1);
    cyc(1, 9, 32'h92, 0, 0, 0, 9);
    chk("x9_wb2_busy", rs2_busy, 1);
    cyc(1, 9, 32'h93, 0, 0, 0, 9);
    chk("x9_wb3_busy", rs2_busy, 0);
    cyc(0, 0, 0, 0, 0, 0, 9);
    chk("x9_clear", rs2_busy, 0);
    chk("x9_data", rs2_data, 32'h93);

    // untracked write to x4
    cyc(1, 4, 32'hCAFE0004, 0, 0, 4, 0);
    chk("x4_untr_busy", rs1_busy, 0);
    cyc(0, 0, 0, 1, 4, 4, 0);
    chk("x4_data", rs1_data, 32'hCAFE0004);
    chk("x4_pre_busy", rs1_busy, 0);
    cyc(0, 0, 0, 0, 0, 4, 0);
    chk("x4_iss_busy", rs1_busy, 1);
    cyc(1, 4, 32'h44, 0, 0, 4, 0);
    chk("x4_wb_busy", rs1_busy, 0);
    cyc(0, 0, 0, 0, 0, 4, 0);
    chk("x4_end_busy", rs1_busy, 0);

    // reset mid-operation clears counts and data
    cyc(0, 0, 0, 1, 11, 0, 0);
    cyc(0, 0, 0, 1, 11, 0, 0);
    cyc(1, 12, 32'h55, 0, 0, 11, 12);
    cyc(0, 0, 0, 0, 0, 11, 12);
    chk("pre_rst_busy", rs1_busy, 1);
    chk("pre_rst_x12", rs2_data, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", rs1_busy, 0);
    chk("mid_rst_x12", rs2_data, 0);
    rs1_addr = 5;
    #1;
    chk("mid_rst_x5", rs1_data, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 11, 9);
    chk("post_rst_busy", rs1_busy, 0);
    chk("post_rst_x9", rs2_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
